// File: rtl/baud_tick_gen_pkg.sv
// Shared constants and elaboration-time helpers for the baud tick generator.
package baud_pkg;

  localparam logic [3:0] SEL_CUSTOM    = 4'd15;
  localparam int         NUM_RATES_DEF = 13;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction

  // Rounded clocks-per-bit for rate (base << sel).
  function automatic longint unsigned baud_div(input longint unsigned clk_hz,
                                               input longint unsigned base,
                                               input int              sel);
    longint unsigned rate;
    rate = base << sel;
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/baud_tick_gen_if.sv
// Config-side bundle: rate select / load in, divisor, strobes and error out.
interface baud_tick_gen_if #(
  parameter int CNT_W = 18
);
  logic             En;
  logic             Load;
  logic [3:0]       Baudsel;
  logic [CNT_W-1:0] Div_in;
  logic [CNT_W-1:0] Baud_val;
  logic             Os_tick;
  logic             Bit_tick;
  logic             Cfg_err;

  modport master (
    output En, Load, Baudsel, Div_in,
    input  Baud_val, Os_tick, Bit_tick, Cfg_err
  );

  modport slave (
    input  En, Load, Baudsel, Div_in,
    output Baud_val, Os_tick, Bit_tick, Cfg_err
  );
endinterface

// File: rtl/baud_tick_gen_frac_acc.sv
// Fractional accumulator: OVERSAMPLE strobes per div_i clocks, exact on average,
// plus a modulo-OVERSAMPLE counter that marks every bit boundary.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int CNT_W      = 18,
  parameter int OVERSAMPLE = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             os_tick_o,
  output logic             bit_tick_o
);

  localparam int OS_CW = (clog2(OVERSAMPLE) < 1) ? 1 : clog2(OVERSAMPLE);
  localparam logic [CNT_W:0]   OS_INC  = (CNT_W+1)'(OVERSAMPLE);
  localparam logic [OS_CW-1:0] OS_LAST = OS_CW'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [OS_CW-1:0] os_cnt_q, os_cnt_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic [CNT_W:0]   sum;

  // Next state: clear on accepted load, step when enabled, otherwise hold.
  always_comb begin
    sum        = {1'b0, acc_q} + OS_INC;
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    if (clr_i) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (en_i) begin
      if (sum >= {1'b0, div_i}) begin
        // acc < div always, so sum - div fits back into CNT_W bits
        acc_d     = CNT_W'(sum - {1'b0, div_i});
        os_tick_d = 1'b1;
        if (os_cnt_q == OS_LAST) begin
          os_cnt_d   = '0;
          bit_tick_d = 1'b1;
        end else begin
          os_cnt_d = os_cnt_q + OS_CW'(1);
        end
      end else begin
        acc_d = CNT_W'(sum);
      end
    end
  end

  // State and registered strobes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc_q      <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
    end
  end

  assign os_tick_o  = os_tick_q;
  assign bit_tick_o = bit_tick_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator top: rate table, load validation, sticky config error,
// and the fractional accumulator that produces Os_tick / Bit_tick.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BASE_BAUD  = 300,
  parameter int          NUM_RATES  = NUM_RATES_DEF,
  parameter int          OVERSAMPLE = 16,
  parameter int          CNT_W      = 18
) (
  input  logic          Clk,
  input  logic          Rst,
  baud_tick_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DIV0   = CNT_W'(baud_div(CLK_HZ, BASE_BAUD, 0));
  localparam logic [CNT_W-1:0] OS_MIN = CNT_W'(OVERSAMPLE);

  logic [CNT_W-1:0] tbl [NUM_RATES];
  logic [CNT_W-1:0] cand_tbl, cand;
  logic [CNT_W-1:0] baud_val_q, baud_val_d;
  logic             cfg_err_q, cfg_err_d;
  logic             load_pend_q;
  logic             is_custom, sel_ok, load_ev, accept, reject;
  logic             os_tick, bit_tick;

  // Divisor table, fixed at elaboration.
  for (genvar i = 0; i < NUM_RATES; i++) begin : g_tbl
    localparam longint unsigned D = baud_div(CLK_HZ, BASE_BAUD, i);
    assign tbl[i] = CNT_W'(D);
  end

  // Table lookup by compare so reserved selects never index past the table.
  always_comb begin
    cand_tbl = '0;
    for (int i = 0; i < NUM_RATES; i++)
      if (32'(bus.Baudsel) == 32'(i)) cand_tbl = tbl[i];
  end

  // Load validation: a reserved select or too-small divisor is rejected.
  always_comb begin
    is_custom = (bus.Baudsel == SEL_CUSTOM);
    sel_ok    = is_custom || (32'(bus.Baudsel) < 32'(NUM_RATES));
    cand      = is_custom ? bus.Div_in : cand_tbl;
    load_ev   = bus.Load | load_pend_q;
    accept    = load_ev & sel_ok & (cand >= OS_MIN);
    reject    = load_ev & ~accept;
    baud_val_d = accept ? cand : baud_val_q;
    cfg_err_d  = cfg_err_q | reject;
  end

  // Divisor, sticky error, and the one-shot load after reset release.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      baud_val_q  <= DIV0;
      cfg_err_q   <= 1'b0;
      load_pend_q <= 1'b1;
    end else begin
      baud_val_q  <= baud_val_d;
      cfg_err_q   <= cfg_err_d;
      load_pend_q <= 1'b0;
    end
  end

  // Any load cycle, accepted or not, freezes the accumulator for that clock.
  baud_frac_acc #(
    .CNT_W      (CNT_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_acc (
    .Clk        (Clk),
    .Rst        (Rst),
    .en_i       (bus.En & ~load_ev),
    .clr_i      (accept),
    .div_i      (baud_val_q),
    .os_tick_o  (os_tick),
    .bit_tick_o (bit_tick)
  );

  assign bus.Baud_val = baud_val_q;
  assign bus.Cfg_err  = cfg_err_q;
  assign bus.Os_tick  = os_tick;
  assign bus.Bit_tick = bit_tick;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at default parameters.
module tb_baud_tick_gen;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  baud_tick_gen_if #(.CNT_W(18)) bus ();

  baud_tick_gen dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  // One active edge, then sample/drive on the falling edge.
  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    bus.En = 1'b1; bus.Load = 1'b0; bus.Baudsel = 4'd12; bus.Div_in = '0;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    vectors++; if (bus.Baud_val !== 18'd166667) begin miscompares++; $display("FAIL rst_baud: got %0d exp 166667", bus.Baud_val); end
    vectors++; if (bus.Os_tick !== 1'b0) begin miscompares++; $display("FAIL rst_os: got %b exp 0", bus.Os_tick); end
    vectors++; if (bus.Bit_tick !== 1'b0) begin miscompares++; $display("FAIL rst_bit: got %b exp 0", bus.Bit_tick); end
    vectors++; if (bus.Cfg_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b exp 0", bus.Cfg_err); end
  endtask

  task automatic test_sel12();
    int first_b, second_b, os_win, last_os, bad_gap, bad_align;
    first_b = -1; second_b = -1; os_win = 0; last_os = -1; bad_gap = 0; bad_align = 0;
    Rst = 1'b0;
    step();  // auto-load edge
    vectors++; if (bus.Baud_val !== 18'd41) begin miscompares++; $display("FAIL s12_baud: got %0d exp 41", bus.Baud_val); end
    for (int c = 1; c <= 82; c++) begin
      step();
      if (bus.Bit_tick) begin
        if (first_b < 0) first_b = c;
        else if (second_b < 0) second_b = c;
        if (!bus.Os_tick) bad_align++;
      end
      if (bus.Os_tick) begin
        if (c > 41) begin
          os_win++;
          if (last_os >= 0 && !((c - last_os) inside {2, 3})) bad_gap++;
        end
        last_os = c;
      end
    end
    vectors++; if (first_b != 41) begin miscompares++; $display("FAIL s12_first_bit: got %0d exp 41", first_b); end
    vectors++; if (second_b != 82) begin miscompares++; $display("FAIL s12_second_bit: got %0d exp 82", second_b); end
    vectors++; if (os_win != 16) begin miscompares++; $display("FAIL s12_os_count: got %0d exp 16", os_win); end
    vectors++; if (bad_gap != 0) begin miscompares++; $display("FAIL s12_os_gap: got %0d bad gaps exp 0", bad_gap); end
    vectors++; if (bad_align != 0) begin miscompares++; $display("FAIL s12_bit_align: got %0d exp 0", bad_align); end
  endtask

  task automatic test_custom();
    int first_b, second_b, os_win;
    first_b = -1; second_b = -1; os_win = 0;
    bus.Baudsel = 4'd15; bus.Div_in = 18'd20; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    vectors++; if (bus.Baud_val !== 18'd20) begin miscompares++; $display("FAIL cus_baud: got %0d exp 20", bus.Baud_val); end
    vectors++; if (bus.Cfg_err !== 1'b0) begin miscompares++; $display("FAIL cus_err: got %b exp 0", bus.Cfg_err); end
    vectors++; if (bus.Os_tick !== 1'b0) begin miscompares++; $display("FAIL cus_load_tick: got %b exp 0", bus.Os_tick); end
    for (int c = 1; c <= 40; c++) begin
      step();
      if (bus.Bit_tick) begin
        if (first_b < 0) first_b = c;
        else if (second_b < 0) second_b = c;
      end
      if (bus.Os_tick && c > 20) os_win++;
    end
    vectors++; if (first_b != 20) begin miscompares++; $display("FAIL cus_first_bit: got %0d exp 20", first_b); end
    vectors++; if (second_b != 40) begin miscompares++; $display("FAIL cus_second_bit: got %0d exp 40", second_b); end
    vectors++; if (os_win != 16) begin miscompares++; $display("FAIL cus_os_count: got %0d exp 16", os_win); end
  endtask

  task automatic test_reject_small();
    int b0, b1;
    b0 = -1; b1 = -1;
    bus.Div_in = 18'd10; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    vectors++; if (bus.Cfg_err !== 1'b1) begin miscompares++; $display("FAIL rej_err: got %b exp 1", bus.Cfg_err); end
    vectors++; if (bus.Baud_val !== 18'd20) begin miscompares++; $display("FAIL rej_baud: got %0d exp 20", bus.Baud_val); end
    for (int c = 1; c <= 60 && b1 < 0; c++) begin
      step();
      if (bus.Bit_tick) begin
        if (b0 < 0) b0 = c; else b1 = c;
      end
    end
    vectors++; if (b0 < 0 || b1 < 0 || (b1 - b0) != 20) begin miscompares++; $display("FAIL rej_period: got %0d exp 20", (b1 < 0) ? -1 : b1 - b0); end
  endtask

  task automatic test_reserved();
    bus.Baudsel = 4'd13; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    vectors++; if (bus.Cfg_err !== 1'b1) begin miscompares++; $display("FAIL res_err: got %b exp 1", bus.Cfg_err); end
    vectors++; if (bus.Baud_val !== 18'd20) begin miscompares++; $display("FAIL res_baud: got %0d exp 20", bus.Baud_val); end
    bus.Baudsel = 4'd5; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    vectors++; if (bus.Baud_val !== 18'd5208) begin miscompares++; $display("FAIL sel5_baud: got %0d exp 5208", bus.Baud_val); end
    vectors++; if (bus.Cfg_err !== 1'b1) begin miscompares++; $display("FAIL sel5_err_sticky: got %b exp 1", bus.Cfg_err); end
  endtask

  task automatic test_en_pause();
    bit found;
    int t, paused_ticks;
    found = 1'b0; t = 0; paused_ticks = 0;
    bus.Baudsel = 4'd12; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (bus.Bit_tick) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL pause_sync: got no Bit_tick exp one within 100 clocks"); end
    repeat (10) begin step(); t++; end
    bus.En = 1'b0;
    repeat (7) begin
      step(); t++;
      if (bus.Os_tick || bus.Bit_tick) paused_ticks++;
    end
    bus.En = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      step(); t++;
      if (bus.Bit_tick) found = 1'b1;
    end
    vectors++; if (paused_ticks != 0) begin miscompares++; $display("FAIL pause_ticks: got %0d exp 0", paused_ticks); end
    vectors++; if (!found || t != 48) begin miscompares++; $display("FAIL pause_next_bit: got %0d exp 48", found ? t : -1); end
  endtask

  task automatic test_reset_mid();
    int first_os, bits;
    first_os = -1; bits = 0;
    bus.Baudsel = 4'd15; bus.Div_in = 18'd20; bus.Load = 1'b1;
    step();
    bus.Load = 1'b0;
    repeat (5) step();
    Rst = 1'b1;
    #1;
    vectors++; if (bus.Baud_val !== 18'd166667) begin miscompares++; $display("FAIL mid_rst_baud: got %0d exp 166667", bus.Baud_val); end
    vectors++; if (bus.Os_tick !== 1'b0) begin miscompares++; $display("FAIL mid_rst_os: got %b exp 0", bus.Os_tick); end
    vectors++; if (bus.Bit_tick !== 1'b0) begin miscompares++; $display("FAIL mid_rst_bit: got %b exp 0", bus.Bit_tick); end
    vectors++; if (bus.Cfg_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b exp 0", bus.Cfg_err); end
    bus.Baudsel = 4'd0;
    step(); step();
    Rst = 1'b0;
    step();  // auto-load edge
    vectors++; if (bus.Baud_val !== 18'd166667) begin miscompares++; $display("FAIL sel0_baud: got %0d exp 166667", bus.Baud_val); end
    for (int c = 1; c <= 10500 && first_os < 0; c++) begin
      step();
      if (bus.Os_tick) first_os = c;
      if (bus.Bit_tick) bits++;
    end
    vectors++; if (first_os != 10417) begin miscompares++; $display("FAIL sel0_first_os: got %0d exp 10417", first_os); end
    vectors++; if (bits != 0) begin miscompares++; $display("FAIL sel0_no_bit: got %0d exp 0", bits); end
  endtask

  initial begin
    test_reset();
    test_sel12();
    test_custom();
    test_reject_small();
    test_reserved();
    test_en_pause();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed baud-value decoder.
- Turns a 4-bit rate select, or a software-supplied custom divisor, into a registered active divisor, then generates exact-average tick strobes from it:
  - Os_tick: OVERSAMPLE pulses per bit time, for the RX sampler.
  - Bit_tick: one pulse per bit time, for the TX engine.
- Sits between the register/config interface and the UART TX/RX cores.
- A new rate can be loaded at runtime without reset.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- BASE_BAUD, 300, baud rate for Baudsel=0; rate for sel n is BASE_BAUD<<n.
- NUM_RATES, 13, number of valid table selects (0..NUM_RATES-1).
- OVERSAMPLE, 16, Os_tick pulses per bit time; must be >=2.
- CNT_W, 18, divisor/accumulator width; must hold round(CLK_HZ/BASE_BAUD).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous active-high reset.
- En  in  1  tick generation enable.
- Load  in  1  single-cycle strobe; latch a new divisor.
- Baudsel  in  4  rate select; 15 = use Div_in; NUM_RATES..14 reserved.
- Div_in  in  CNT_W  custom divisor, used when Baudsel=15.
- Baud_val  out  CNT_W  active divisor in clocks per bit (registered).
- Os_tick  out  1  oversample strobe, one Clk wide.
- Bit_tick  out  1  bit-time strobe, one Clk wide.
- Cfg_err  out  1  sticky flag: a load was rejected.

Behaviour:
- Reset values (async):
  - Baud_val = TABLE[0] = round(CLK_HZ/BASE_BAUD) = 166667.
  - acc = 0, os_cnt = 0.
  - Os_tick = 0, Bit_tick = 0, Cfg_err = 0.
  - load_pend = 1.
- Divisor table: TABLE[n] = (CLK_HZ + (BASE_BAUD<<n)/2) / (BASE_BAUD<<n), computed at elaboration.
  - Default values: 166667, 83333, 41667, 20833, 10417, 5208, 2604, 1302, 651, 326, 163, 81, 41.
- Load event: Load=1, or load_pend=1. load_pend gives an automatic load in the first clock after reset release; it clears on any load event.
  - Candidate divisor: TABLE[Baudsel] if Baudsel<NUM_RATES; Div_in if Baudsel=15.
  - Accept when Baudsel is valid and candidate >= OVERSAMPLE: Baud_val <= candidate, acc <= 0, os_cnt <= 0, no tick in that cycle.
  - Reject when Baudsel is reserved, or candidate < OVERSAMPLE: Baud_val, acc and os_cnt unchanged; Cfg_err <= 1 (sticky until Rst). Ticks continue on the old divisor.
- Tick engine, in a cycle with En=1 and no load event:
  - s = acc + OVERSAMPLE, computed in CNT_W+1 bits.
  - If s >= Baud_val: acc <= s - Baud_val, Os_tick <= 1.
  - Otherwise: acc <= s.
  - acc < Baud_val always holds, so the subtraction never underflows.
- Bit_tick is asserted in the same cycle as the Os_tick that takes os_cnt from OVERSAMPLE-1 back to 0; os_cnt wraps modulo OVERSAMPLE.
- Cadence: exactly OVERSAMPLE Os_ticks and exactly one Bit_tick every Baud_val enabled clocks. Os_tick spacing jitters by at most 1 clock.
- En=0: acc and os_cnt hold, ticks are 0. Resuming continues the phase; there is no restart.
- Load with En=0: the load still applies.
- Outputs are registered, so a tick appears 1 clock after the accumulator cycle that crossed the threshold.
- Rst mid-operation clears everything immediately. The table-0 divisor applies until the auto-load occurs.

Decomposition:
- Package baud_pkg:
  - Function baud_div(clk_hz, base, sel) returning the rounded divisor.
  - Constants SEL_CUSTOM=4'd15 and default NUM_RATES.
  - CNT_W sizing function clog2.
- Sub-module baud_frac_acc: the accumulator plus os_cnt, producing the Os_tick and Bit_tick strobes. The top level holds the table, load/validate logic and Cfg_err.

Test Plan:
- Reset release, Baudsel=12, En=1 -> Baud_val=41 one clock after release; Bit_tick every 41 clocks; 16 Os_ticks per 41-clock window; Os_tick gaps are 2 or 3.
- Baudsel=15, Div_in=20, Load -> Baud_val=20; Bit_tick period 20; 16 Os_ticks per 20 clocks; Cfg_err=0.
- Baudsel=15, Div_in=10, Load -> Cfg_err=1; Baud_val stays 20; tick cadence undisturbed.
- Baudsel=13, Load -> Cfg_err=1, Baud_val unchanged. Then a valid load of sel 5 -> Baud_val=5208 and Cfg_err stays 1.
- Sel 12, drop En for 7 clocks mid-bit -> no ticks while En=0; the next Bit_tick arrives exactly 7 clocks later than it otherwise would.
- Assert Rst mid-frame at sel 15 / Div=20 -> outputs clear immediately and Baud_val=166667 during reset. After release, auto-load with Baudsel=0 gives Baud_val=166667 and the first Bit_tick 166667 clocks later.
